// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display feeder.
package seg_disp_pkg;

    // Number of packed BCD digits presented to the driver
    localparam int DIGITS = 8;

    // Width of the binary display value
    localparam int unsigned BIN_W = 27;

    // Largest value representable in DIGITS decimal digits
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    // Shown instead of the BCD result when saturation is enabled
    localparam logic [31:0] SAT_PATTERN = 32'h9999_9999;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StHold
    } state_e;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by
// one bit with carry_in entering at bit 0.
module bcd_dd_step
    import seg_disp_pkg::*;
(
    input  logic [31:0] bcd_in,
    input  logic        carry_in,
    output logic [31:0] bcd_out
);

    logic [31:0] adj;
    logic        unused_msb;

    // Per-nibble add-3 correction ahead of the shift
    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of digit 7 only matters for out-of-range values,
    // which are replaced downstream anyway.
    assign unused_msb = adj[31];
    assign bcd_out    = {adj[30:0], carry_in};

endmodule

// File: rtl/bcd_disp_feeder.sv
// Binary-to-BCD feeder for the serial 8-digit seven-segment driver.
// Converts one bit per clock, then holds num/start for HOLD_CYCLES so the
// driver latches it. One request arriving mid-refresh is queued (latest wins).
// Build option: define BCD_SAT_EN to show 99999999 for out-of-range values;
// otherwise out-of-range values are shown as raw zero-extended hex.
module bcd_disp_feeder
    import seg_disp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 72,
    parameter int unsigned BIN_W       = 27
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [BIN_W-1:0] value,
    input  logic             value_valid,
    output logic [31:0]      num,
    output logic             start,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);

    state_e           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BIN_W-1:0] val_q, val_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [4:0]       step_q, step_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             pend_q, pend_d;
    logic [BIN_W-1:0] pend_val_q, pend_val_d;
    logic [31:0]      num_q, num_d;
    logic             start_q, start_d;
    logic             ovf_q, ovf_d;
    logic             busy_q;

    logic [31:0]      bcd_next;
    logic             out_of_range;
    logic [31:0]      raw_hex;

    bcd_dd_step u_step (
        .bcd_in   (bcd_q),
        .carry_in (bin_q[BIN_W-1]),
        .bcd_out  (bcd_next)
    );

    assign raw_hex      = {{(32 - BIN_W){1'b0}}, val_q};
    assign out_of_range = raw_hex > MAX_DEC;

    // Next-state, datapath and output-register decode
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        val_d      = val_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        num_d      = num_q;
        start_d    = start_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (value_valid) begin
                    bin_d   = value;
                    val_d   = value;
                    bcd_d   = '0;
                    step_d  = '0;
                    state_d = StConv;
                end
            end

            StConv: begin
                if (value_valid) begin
                    pend_d     = 1'b1;
                    pend_val_d = value;
                end
                if (step_q == 5'(BIN_W)) begin
                    // All bits consumed: publish result and start the hold
`ifdef BCD_SAT_EN
                    num_d = out_of_range ? SAT_PATTERN : bcd_q;
`else
                    num_d = out_of_range ? raw_hex : bcd_q;
`endif
                    ovf_d   = out_of_range;
                    start_d = 1'b1;
                    hold_d  = '0;
                    state_d = StHold;
                end else begin
                    bcd_d  = bcd_next;
                    bin_d  = {bin_q[BIN_W-2:0], 1'b0};
                    step_d = step_q + 5'd1;
                end
            end

            StHold: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    start_d = 1'b0;
                    // A request on this very edge is newer than any queued one
                    if (value_valid) begin
                        bin_d   = value;
                        val_d   = value;
                        bcd_d   = '0;
                        step_d  = '0;
                        pend_d  = 1'b0;
                        state_d = StConv;
                    end else if (pend_q) begin
                        bin_d   = pend_val_q;
                        val_d   = pend_val_q;
                        bcd_d   = '0;
                        step_d  = '0;
                        pend_d  = 1'b0;
                        state_d = StConv;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                    if (value_valid) begin
                        pend_d     = 1'b1;
                        pend_val_d = value;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                start_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            val_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            num_q      <= '0;
            start_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            val_q      <= val_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            num_q      <= num_d;
            start_q    <= start_d;
            ovf_q      <= ovf_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign num   = num_q;
    assign start = start_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bcd_disp_feeder.sv
// Directed self-checking bench for bcd_disp_feeder (default HOLD_CYCLES = 72).
module tb_bcd_disp_feeder;

    logic        clk;
    logic        rstn;
    logic [26:0] value;
    logic        value_valid;
    logic [31:0] num;
    logic        start;
    logic        busy;
    logic        ovf;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned b_seen   = 0;

    bcd_disp_feeder #(
        .HOLD_CYCLES (72),
        .BIN_W       (27)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .value       (value),
        .value_valid (value_valid),
        .num         (num),
        .start       (start),
        .busy        (busy),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch for the dropped request B ever reaching the display
    always @(negedge clk) begin
        if (num == 32'h0000_0022) b_seen <= b_seen + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one request; returns 1 time unit after the sampling edge N
    task automatic pulse_req(input logic [26:0] v);
        @(negedge clk);
        value       = v;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    // Counts cycles start stays high, starting just after its rising edge
    task automatic wait_hold_end(output int unsigned len);
        len = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (start) len++;
            else break;
        end
    endtask

    task automatic run_refresh(input string tag, input logic [26:0] v,
                               input logic [31:0] exp_num, input logic exp_ovf);
        int unsigned len;
        pulse_req(v);
        check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
        repeat (27) @(posedge clk);
        #1;
        check_eq({tag, "_start_early"}, 32'(start), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_num"}, num, exp_num);
        check_eq({tag, "_start"}, 32'(start), 32'd1);
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        wait_hold_end(len);
        check_eq({tag, "_hold_len"}, len, 32'd72);
        check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned len;
        rstn        = 1'b0;
        value       = '0;
        value_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_num", num, 32'h0);
        check_eq("rst_start", 32'(start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        run_refresh("v12345678", 27'd12_345_678, 32'h1234_5678, 1'b0);
        run_refresh("v0", 27'd0, 32'h0000_0000, 1'b0);
        run_refresh("v99999999", 27'd99_999_999, 32'h9999_9999, 1'b0);
`ifdef BCD_SAT_EN
        run_refresh("v1e8", 27'd100_000_000, 32'h9999_9999, 1'b1);
`else
        run_refresh("v1e8", 27'd100_000_000, 32'h05F5_E100, 1'b1);
`endif
        run_refresh("v907", 27'd907, 32'h0000_0907, 1'b0);

        // A in IDLE, B and C during CONV: only A and C are shown
        pulse_req(27'd11);
        repeat (4) @(posedge clk);
        pulse_req(27'd22);
        repeat (4) @(posedge clk);
        pulse_req(27'd33);
        // now at N+10 (+1)
        repeat (18) @(posedge clk);
        #1;
        check_eq("abc_a_num", num, 32'h0000_0011);
        check_eq("abc_a_start", 32'(start), 32'd1);
        wait_hold_end(len);
        check_eq("abc_a_len", len, 32'd72);
        check_eq("abc_gap_busy", 32'(busy), 32'd1);
        repeat (27) @(posedge clk);
        #1;
        check_eq("abc_c_early", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        check_eq("abc_c_num", num, 32'h0000_0033);
        check_eq("abc_c_start", 32'(start), 32'd1);
        wait_hold_end(len);
        check_eq("abc_c_len", len, 32'd72);
        check_eq("abc_idle", 32'(busy), 32'd0);
        check_eq("abc_b_never", b_seen, 32'd0);

        // Asynchronous reset in the middle of HOLD
        pulse_req(27'd100_000_000);
        repeat (28) @(posedge clk);
        #1;
        check_eq("mid_ovf_before", 32'(ovf), 32'd1);
        check_eq("mid_start_before", 32'(start), 32'd1);
        repeat (10) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_start", 32'(start), 32'd0);
        check_eq("mid_rst_num", num, 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        run_refresh("post_rst", 27'd4321, 32'h0000_4321, 1'b0);

        // Request coincident with the HOLD->IDLE edge
        pulse_req(27'd7);
        repeat (28) @(posedge clk);
        #1;
        check_eq("coin_first_num", num, 32'h0000_0007);
        repeat (71) @(posedge clk);
        #1;
        check_eq("coin_start_last", 32'(start), 32'd1);
        pulse_req(27'd8);
        check_eq("coin_start_fell", 32'(start), 32'd0);
        check_eq("coin_busy_edge", 32'(busy), 32'd1);
        repeat (27) @(posedge clk);
        #1;
        check_eq("coin_busy_conv", 32'(busy), 32'd1);
        check_eq("coin_start_early", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        check_eq("coin_num", num, 32'h0000_0008);
        check_eq("coin_start", 32'(start), 32'd1);
        wait_hold_end(len);
        check_eq("coin_len", len, 32'd72);
        check_eq("coin_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
